// File: rtl/alu_issue_queue_pkg.sv
// Shared types and constants for the ALU issue queue: field widths, ALU opcodes
// and the packed payload stored in every queue slot.
package alu_issue_queue_pkg;

  localparam int WIDTH_REG  = 7;
  localparam int WIDTH_UOP  = 7;
  localparam int WIDTH_FUNC = 10;

  typedef enum logic [WIDTH_UOP-1:0] {
    UOP_OP     = 7'b0110011,
    UOP_OP_IMM = 7'b0010011,
    UOP_LUI    = 7'b0110111,
    UOP_AUIPC  = 7'b0010111
  } alu_uop_e;

  typedef logic [WIDTH_REG-1:0] preg_t;

  typedef struct packed {
    logic [WIDTH_UOP-1:0]  uop;
    logic [WIDTH_FUNC-1:0] func;
    preg_t                 prd;
    preg_t                 prs1;
    logic                  rdy1;
    preg_t                 prs2;
    logic                  rdy2;
    logic [31:0]           imm;
    logic [31:0]           pc;
  } iq_entry_t;

  // Physical x0 never waits on a producer.
  function automatic logic src_ready(input logic rdy, input preg_t tag);
    return rdy | (tag == '0);
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, wakeup and issue signals of the ALU issue queue. The master side
// (rename/dispatch plus the bypass network) drives i_*, the queue drives o_*.
interface alu_issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int NWAKE = 2
);
  import alu_issue_queue_pkg::*;

  logic                       i_flush;
  logic                       i_disp_valid;
  logic                       o_disp_ready;
  logic [WIDTH_UOP-1:0]       i_disp_uop;
  logic [WIDTH_FUNC-1:0]      i_disp_func;
  logic [WIDTH_REG-1:0]       i_disp_prd;
  logic [WIDTH_REG-1:0]       i_disp_prs1;
  logic [WIDTH_REG-1:0]       i_disp_prs2;
  logic                       i_disp_rdy1;
  logic                       i_disp_rdy2;
  logic [31:0]                i_disp_imm;
  logic [31:0]                i_disp_pc;
  logic [NWAKE-1:0]           i_wake_valid;
  logic [NWAKE*WIDTH_REG-1:0] i_wake_tag;
  logic                       o_valid;
  logic [WIDTH_UOP-1:0]       o_uop;
  logic [WIDTH_FUNC-1:0]      o_func;
  logic [WIDTH_REG-1:0]       o_prd;
  logic [WIDTH_REG-1:0]       o_prs1;
  logic [WIDTH_REG-1:0]       o_prs2;
  logic [31:0]                o_imm;
  logic [31:0]                o_pc;
  logic [$clog2(DEPTH):0]     o_count;

  modport master (
    output i_flush, i_disp_valid, i_disp_uop, i_disp_func, i_disp_prd,
           i_disp_prs1, i_disp_prs2, i_disp_rdy1, i_disp_rdy2, i_disp_imm,
           i_disp_pc, i_wake_valid, i_wake_tag,
    input  o_disp_ready, o_valid, o_uop, o_func, o_prd, o_prs1, o_prs2,
           o_imm, o_pc, o_count
  );

  modport slave (
    input  i_flush, i_disp_valid, i_disp_uop, i_disp_func, i_disp_prd,
           i_disp_prs1, i_disp_prs2, i_disp_rdy1, i_disp_rdy2, i_disp_imm,
           i_disp_pc, i_wake_valid, i_wake_tag,
    output o_disp_ready, o_valid, o_uop, o_func, o_prd, o_prs1, o_prs2,
           o_imm, o_pc, o_count
  );
endinterface

// File: rtl/alu_issue_queue_iq_entry.sv
// One issue-queue slot: holds a µop, takes a new dispatch or the entry shifted
// down from the slot above, and sets source-ready bits on matching wakeup tags.
module iq_entry
  import alu_issue_queue_pkg::*;
#(
  parameter int NW = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    load,
  input  logic                    shift,
  input  iq_entry_t               disp_data,
  input  logic                    upper_vld,
  input  iq_entry_t               upper_data,
  input  logic [NW-1:0]           wake_valid,
  input  logic [NW*WIDTH_REG-1:0] wake_tag,
  output logic                    vld,
  output iq_entry_t               data,
  output logic                    ready
);

  logic      nxt_vld;
  iq_entry_t nxt;

  // Tag 0 on a wakeup port never matches anything.
  function automatic logic woken(input preg_t tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (wake_valid[k] && (wake_tag[k*WIDTH_REG +: WIDTH_REG] == tag) && (tag != '0))
        hit = 1'b1;
    end
    return hit;
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    nxt_vld = vld;
    nxt     = data;
    if (load) begin
      nxt_vld  = 1'b1;
      nxt      = disp_data;
      nxt.rdy1 = src_ready(disp_data.rdy1, disp_data.prs1);
      nxt.rdy2 = src_ready(disp_data.rdy2, disp_data.prs2);
    end else if (shift) begin
      nxt_vld = upper_vld;
      nxt     = upper_data;
    end
    nxt.rdy1 = nxt.rdy1 | woken(nxt.prs1);
    nxt.rdy2 = nxt.rdy2 | woken(nxt.prs2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) vld <= 1'b0;
    else                 vld <= nxt_vld;
  end

  // NOTE: the payload has no reset; it is only observed while vld is set.
  always_ff @(posedge clk) begin
    data <= nxt;
  end

  assign ready = vld & data.rdy1 & data.rdy2;

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing age-ordered ALU issue queue: oldest-ready select, shift-down on
// issue. Optional macro ALU_SPEC_WAKEUP_EN adds the issuing prd as a wakeup tag.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NWAKE = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  alu_issue_queue_if.slave q
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
`ifdef ALU_SPEC_WAKEUP_EN
  localparam int NW = NWAKE + 1;
`else
  localparam int NW = NWAKE;
`endif

  logic [CW-1:0]           cnt, cnt_next, disp_idx;
  logic                    disp_ready, disp_acc, issued;
  logic [IW-1:0]           sel_idx;
  logic [DEPTH:0]          ent_vld;
  iq_entry_t               ent_data [DEPTH+1];
  logic [DEPTH-1:0]        ent_rdy, ent_load, ent_shift;
  iq_entry_t               disp_data, sel_data, issue_data;
  logic [NW-1:0]           wk_valid;
  logic [NW*WIDTH_REG-1:0] wk_tag;

  assign disp_data = '{uop: q.i_disp_uop, func: q.i_disp_func, prd: q.i_disp_prd,
                       prs1: q.i_disp_prs1, rdy1: q.i_disp_rdy1,
                       prs2: q.i_disp_prs2, rdy2: q.i_disp_rdy2,
                       imm: q.i_disp_imm, pc: q.i_disp_pc};

  // Descending scan: the last hit is the lowest (oldest) ready slot.
  always_comb begin
    issued  = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        issued  = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign sel_data   = ent_data[{1'b0, sel_idx}];
  assign issue_data = issued ? sel_data : '0;

  // A new µop lands in the first free slot after this cycle's collapse.
  assign disp_acc = q.i_disp_valid & disp_ready;
  assign disp_idx = cnt - CW'(issued);
  assign cnt_next = cnt + CW'(disp_acc) - CW'(issued);

  always_comb begin
    ent_load  = '0;
    ent_shift = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_load[i]  = disp_acc && (disp_idx == CW'(i));
      ent_shift[i] = issued && (IW'(i) >= sel_idx);
    end
  end

`ifdef ALU_SPEC_WAKEUP_EN
  assign wk_valid = {issued, q.i_wake_valid};
  assign wk_tag   = {sel_data.prd, q.i_wake_tag};
`else
  assign wk_valid = q.i_wake_valid;
  assign wk_tag   = q.i_wake_tag;
`endif

  // Ready is registered from the next count, so a full queue stays closed even
  // in a cycle that also issues.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || q.i_flush) begin
      cnt        <= '0;
      disp_ready <= 1'b1;
    end else begin
      cnt        <= cnt_next;
      disp_ready <= (cnt_next < CW'(DEPTH));
    end
  end

  assign ent_vld[DEPTH]  = 1'b0;
  assign ent_data[DEPTH] = '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    iq_entry #(.NW(NW)) u_entry (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .flush      (q.i_flush),
      .load       (ent_load[g]),
      .shift      (ent_shift[g]),
      .disp_data  (disp_data),
      .upper_vld  (ent_vld[g+1]),
      .upper_data (ent_data[g+1]),
      .wake_valid (wk_valid),
      .wake_tag   (wk_tag),
      .vld        (ent_vld[g]),
      .data       (ent_data[g]),
      .ready      (ent_rdy[g])
    );
  end

  assign q.o_disp_ready = disp_ready;
  assign q.o_count      = cnt;
  assign q.o_valid      = issued;
  assign q.o_uop        = issue_data.uop;
  assign q.o_func       = issue_data.func;
  assign q.o_prd        = issue_data.prd;
  assign q.o_prs1       = issue_data.prs1;
  assign q.o_prs2       = issue_data.prs2;
  assign q.o_imm        = issue_data.imm;
  assign q.o_pc         = issue_data.pc;

endmodule
